led_sequencer: RTL and testbench
================================

# led_sequencer

Display controller for the 8-LED bank: sequences COUNT, SCAN and BREATHE patterns from a programmable prescaler tick, with freeze and pause control. It replaces a free-running counter tapped directly onto the LEDs. It sits between the board clock and the LED pins, with mode/pause driven by synchronised switch inputs.

## Interface
- TICK_DIV, default 8388608: prescaler period in clocks; ≥ 2.
- ipClk  in  1  system clock; all logic on rising edge.
- ipnReset  in  1  asynchronous, active-low reset.
- ipMode  in  2  pattern select: 0 COUNT, 1 SCAN, 2 BREATHE, 3 HOLD. Synchronous to ipClk.
- ipPause  in  1  when high, suppresses pattern ticks. Synchronous.
- opLED  out  8  registered LED drive; bit 0 = LED 0.

## Operation
- **Prescaler:** pcnt counts 0..TICK_DIV-1 and wraps. tick = 1 for exactly one cycle when pcnt == TICK_DIV-1 and ipPause = 0. While ipPause = 1, pcnt holds.
- **Mode register:** mode_q samples ipMode.
  - When ipMode != mode_q, on that edge: mode_q <= ipMode and pcnt <= 0.
  - If the new mode is not HOLD, its pattern state is also reinitialised.
  - A tick coinciding with a mode change is discarded; the change wins.
- **COUNT:**
  - cnt (8 bit) init 0; +1 per tick; wraps 255 → 0.
  - opLED = cnt.
- **SCAN:**
  - pos (3 bit) init 0, dir init UP.
  - Per tick: UP and pos < 7 → pos+1; UP and pos == 7 → pos 6, dir DOWN.
  - DOWN and pos > 0 → pos-1; DOWN and pos == 0 → pos 1, dir UP.
  - opLED = 1 << pos. Sequence: 0,1..7,6..0,1…
- **BREATHE:**
  - duty (8 bit) init 0, dir UP.
  - Per tick: step by ±1. At 255 while UP → 254, DOWN. At 0 while DOWN → 1, UP.
  - pwm (8 bit) free-runs +1 every clock, including while paused.
  - All 8 LEDs = (pwm < duty). duty 0 → always off; 255 → on 255 of 256 cycles.
- **HOLD:**
  - opLED holds its last value; pattern state frozen.
  - pwm keeps running but is not applied.
  - Leaving HOLD is a mode change, so the target pattern restarts from its init values.
- **Reset:** all registers clear immediately on ipnReset low.
  - Reset values: opLED = 0x00, mode_q = COUNT, pcnt = 0, cnt = 0, pos = 0, duty = 0, dir = UP, pwm = 0.
  - Reset mid-pattern discards all state; no partial outputs.

## Timing
- After reset release, the first tick is asserted during the TICK_DIV-th clock cycle.
- Each later tick follows TICK_DIV cycles after the previous one, unpaused.
- Pattern state and opLED update on the same edge that samples tick = 1. The new pattern is visible immediately after that edge (latency 1 cycle from tick).
- Mode change takes effect on the edge sampling the new ipMode; opLED shows the new mode's init pattern after that edge.
  - COUNT init: 0x00. SCAN init: 0x01. BREATHE init: 0x00 (duty 0).
  - HOLD: opLED unchanged.
- BREATHE: opLED is updated every clock from the registered pwm/duty compare, with no extra pipeline stage.
- Pause takes effect on the edge it is sampled. Releasing pause resumes from the held pcnt; a held pcnt == TICK_DIV-1 ticks in the first unpaused cycle.

## Structure
- Package led_seq_pkg holds:
  - mode typedef (2 bit): MODE_COUNT = 0, MODE_SCAN = 1, MODE_BREATHE = 2, MODE_HOLD = 3.
  - dir typedef: DIR_UP, DIR_DOWN.
  - constants SCAN_LAST = 7 and DUTY_MAX = 255.
- Sub-module led_tick_gen holds the prescaler.
  - Parameter: TICK_DIV.
  - Ports: ipClk, ipnReset, ipPause, ipClear, opTick.
  - ipClear is driven high on mode change.
- Pattern registers and the output mux live in led_sequencer.

## Test plan
All scenarios use TICK_DIV = 4.
- **Reset/COUNT:** ipMode = 0, release reset.
  - opLED = 0x00 for 3 cycles, then 0x01, 0x02… every 4 cycles.
  - After 256 ticks opLED = 0x00 (wrap).
- **SCAN bounce:** ipMode = 1.
  - opLED sequence per tick: 0x01, 0x02…0x80, 0x40…0x01, 0x02.
  - No repeated 0x80 or 0x01 at the ends.
- **BREATHE:** ipMode = 2, run to duty = 3.
  - opLED = 0xFF exactly when pwm ∈ {0,1,2}, i.e. 3 of every 256 cycles.
  - duty turns at 255 → 254 and at 0 → 1.
- **Pause/HOLD:**
  - ipPause = 1 for 10 cycles mid-COUNT: opLED constant, then resumes with the same pcnt phase.
  - ipMode = 3: opLED frozen; switch to 1 → opLED = 0x01 on the next edge.
- **Mode change collides with tick:** change ipMode 0 → 1 in the cycle tick = 1.
  - opLED = 0x01 (SCAN init, tick discarded).
  - Next tick arrives exactly 4 cycles later.
- **Async reset mid-run:** assert ipnReset low between clock edges in BREATHE.
  - opLED = 0x00 immediately, without waiting for an edge.
  - After release, behaviour matches scenario 1.

Source files
------------

// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED pattern sequencer.
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_COUNT   = 2'd0,
        MODE_SCAN    = 2'd1,
        MODE_BREATHE = 2'd2,
        MODE_HOLD    = 2'd3
    } mode_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    localparam logic [2:0] SCAN_LAST = 3'd7;
    localparam logic [7:0] DUTY_MAX  = 8'd255;

    // One-hot LED image for a scan position.
    function automatic logic [7:0] scan_onehot(input logic [2:0] pos);
        return 8'd1 << pos;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Prescaler: free-running modulo-TICK_DIV counter producing a one-cycle
// pattern tick. The count freezes while paused and restarts on clear.
module led_tick_gen #(
    parameter int TICK_DIV = 8388608
) (
    input  logic ipClk,
    input  logic ipnReset,
    input  logic ipPause,
    input  logic ipClear,
    output logic opTick
);

    localparam int W = $clog2(TICK_DIV);
    localparam logic [W-1:0] PCNT_LAST = W'(TICK_DIV - 1);

    logic [W-1:0] r_pcnt;
    logic         w_last;

    assign w_last = (r_pcnt == PCNT_LAST);
    // Tick is combinational so the pattern logic sees it in the same cycle
    // the counter sits on its last value.
    assign opTick = w_last && !ipPause;

    // Prescaler count: clear wins over pause, pause holds the phase.
    always_ff @(posedge ipClk or negedge ipnReset) begin
        if (!ipnReset) begin
            r_pcnt <= '0;
        end else if (ipClear) begin
            r_pcnt <= '0;
        end else if (!ipPause) begin
            r_pcnt <= w_last ? '0 : r_pcnt + 1'b1;
        end
    end

endmodule

// File: rtl/led_sequencer.sv
// 8-LED display controller: COUNT / SCAN / BREATHE / HOLD patterns advanced
// by a prescaler tick. A mode change restarts the prescaler and the target
// pattern, and swallows any tick landing on the same edge.
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int TICK_DIV = 8388608
) (
    input  logic       ipClk,
    input  logic       ipnReset,
    input  logic [1:0] ipMode,
    input  logic       ipPause,
    output logic [7:0] opLED
);

    mode_t      r_mode,        w_mode_nxt;
    logic [7:0] r_cnt,         w_cnt_nxt;
    logic [2:0] r_pos,         w_pos_nxt;
    dir_t       r_scan_dir,    w_scan_dir_nxt;
    logic [7:0] r_duty,        w_duty_nxt;
    dir_t       r_breathe_dir, w_breathe_dir_nxt;
    logic [7:0] r_pwm;
    logic [7:0] r_led,         w_led_nxt;

    logic       w_mode_chg;
    logic       w_tick_raw;
    logic       w_tick;

    assign w_mode_chg = (ipMode != r_mode);
    assign w_tick     = w_tick_raw && !w_mode_chg;
    assign opLED      = r_led;

    led_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .ipClk    (ipClk),
        .ipnReset (ipnReset),
        .ipPause  (ipPause),
        .ipClear  (w_mode_chg),
        .opTick   (w_tick_raw)
    );

    // Next pattern state and LED image; a mode change overrides any tick.
    always_comb begin
        w_mode_nxt        = r_mode;
        w_cnt_nxt         = r_cnt;
        w_pos_nxt         = r_pos;
        w_scan_dir_nxt    = r_scan_dir;
        w_duty_nxt        = r_duty;
        w_breathe_dir_nxt = r_breathe_dir;
        w_led_nxt         = r_led;

        if (w_mode_chg) begin
            w_mode_nxt = mode_t'(ipMode);
            case (mode_t'(ipMode))
                MODE_COUNT: begin
                    w_cnt_nxt = 8'd0;
                    w_led_nxt = 8'd0;
                end
                MODE_SCAN: begin
                    w_pos_nxt      = 3'd0;
                    w_scan_dir_nxt = DIR_UP;
                    w_led_nxt      = scan_onehot(3'd0);
                end
                MODE_BREATHE: begin
                    w_duty_nxt        = 8'd0;
                    w_breathe_dir_nxt = DIR_UP;
                    w_led_nxt         = 8'd0;
                end
                MODE_HOLD: begin
                    w_led_nxt = r_led;
                end
            endcase
        end else begin
            case (r_mode)
                MODE_COUNT: begin
                    if (w_tick) begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end
                    w_led_nxt = w_cnt_nxt;
                end
                MODE_SCAN: begin
                    if (w_tick) begin
                        if (r_scan_dir == DIR_UP) begin
                            if (r_pos == SCAN_LAST) begin
                                w_pos_nxt      = SCAN_LAST - 3'd1;
                                w_scan_dir_nxt = DIR_DOWN;
                            end else begin
                                w_pos_nxt = r_pos + 3'd1;
                            end
                        end else begin
                            if (r_pos == 3'd0) begin
                                w_pos_nxt      = 3'd1;
                                w_scan_dir_nxt = DIR_UP;
                            end else begin
                                w_pos_nxt = r_pos - 3'd1;
                            end
                        end
                    end
                    w_led_nxt = scan_onehot(w_pos_nxt);
                end
                MODE_BREATHE: begin
                    if (w_tick) begin
                        if (r_breathe_dir == DIR_UP) begin
                            if (r_duty == DUTY_MAX) begin
                                w_duty_nxt        = DUTY_MAX - 8'd1;
                                w_breathe_dir_nxt = DIR_DOWN;
                            end else begin
                                w_duty_nxt = r_duty + 8'd1;
                            end
                        end else begin
                            if (r_duty == 8'd0) begin
                                w_duty_nxt        = 8'd1;
                                w_breathe_dir_nxt = DIR_UP;
                            end else begin
                                w_duty_nxt = r_duty - 8'd1;
                            end
                        end
                    end
                    // Compare uses the registered pwm/duty directly, so the
                    // LED lags the compare inputs by exactly one edge.
                    w_led_nxt = {8{r_pwm < r_duty}};
                end
                MODE_HOLD: begin
                    w_led_nxt = r_led;
                end
            endcase
        end
    end

    // Pattern state, LED output and the free-running PWM phase.
    always_ff @(posedge ipClk or negedge ipnReset) begin
        if (!ipnReset) begin
            r_mode        <= MODE_COUNT;
            r_cnt         <= 8'd0;
            r_pos         <= 3'd0;
            r_scan_dir    <= DIR_UP;
            r_duty        <= 8'd0;
            r_breathe_dir <= DIR_UP;
            r_pwm         <= 8'd0;
            r_led         <= 8'd0;
        end else begin
            r_mode        <= w_mode_nxt;
            r_cnt         <= w_cnt_nxt;
            r_pos         <= w_pos_nxt;
            r_scan_dir    <= w_scan_dir_nxt;
            r_duty        <= w_duty_nxt;
            r_breathe_dir <= w_breathe_dir_nxt;
            r_pwm         <= r_pwm + 8'd1;
            r_led         <= w_led_nxt;
        end
    end

endmodule

// File: tb/tb_led_sequencer.sv
// Bench for led_sequencer with TICK_DIV = 4. The driver pushes the expected
// LED value for every clock into a queue; a monitor pops and compares.
module tb_led_sequencer;

    localparam int TD = 4;

    logic       ipClk    = 1'b0;
    logic       ipnReset = 1'b0;
    logic [1:0] ipMode   = 2'd0;
    logic       ipPause  = 1'b0;
    logic [7:0] opLED;

    always #5 ipClk = ~ipClk;

    led_sequencer #(.TICK_DIV(TD)) dut (
        .ipClk    (ipClk),
        .ipnReset (ipnReset),
        .ipMode   (ipMode),
        .ipPause  (ipPause),
        .opLED    (opLED)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];

    // Reference model: ticks since pattern entry, prescaler phase, pwm phase.
    int         m_mode;
    int         m_phase;
    int         m_n;
    int         m_pwm;
    logic [7:0] m_led;

    // LED image after n ticks in a mode; patterns expressed as closed forms.
    function automatic logic [7:0] pattern(input int mode, input int n,
                                           input int pwm, input logic [7:0] held);
        int t;
        int d;
        case (mode)
            0: return 8'(n % 256);
            1: begin
                t = n % 14;
                return 8'(1 << ((t <= 7) ? t : 14 - t));
            end
            2: begin
                d = n % 510;
                d = (d <= 255) ? d : 510 - d;
                return (pwm < d) ? 8'hFF : 8'h00;
            end
            default: return held;
        endcase
    endfunction

    task automatic model_reset();
        m_mode  = 0;
        m_phase = 0;
        m_n     = 0;
        m_pwm   = 0;
        m_led   = 8'h00;
    endtask

    // Drive one clock's worth of inputs and queue the expected LED value.
    task automatic step(input int mode, input bit pause);
        bit tick;
        @(negedge ipClk);
        ipMode  = 2'(mode);
        ipPause = pause;
        if (mode != m_mode) begin
            m_mode  = mode;
            m_phase = 0;
            if (mode != 3) m_n = 0;
            m_led = pattern(mode, 0, m_pwm, m_led);
        end else begin
            tick = (m_phase == TD - 1) && !pause;
            if (mode == 2) m_led = pattern(2, m_n, m_pwm, m_led);
            if (!pause) m_phase = (m_phase + 1) % TD;
            if (tick && mode != 3) m_n++;
            if (mode == 0 || mode == 1) m_led = pattern(mode, m_n, m_pwm, m_led);
        end
        m_pwm = (m_pwm + 1) % 256;
        exp_q.push_back(m_led);
    endtask

    logic [7:0] mon_exp;

    // Monitor: one expected value per clock edge.
    always @(posedge ipClk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            n_checks++;
            if (opLED !== mon_exp) begin
                n_fail++;
                $display("FAIL led_value t=%0t opLED=%h expected=%h mode=%0d",
                         $time, opLED, mon_exp, m_mode);
            end
        end
    end

    task automatic check_now(input string name, input logic [7:0] want);
        n_checks++;
        if (opLED !== want) begin
            n_fail++;
            $display("FAIL %s t=%0t opLED=%h expected=%h", name, $time, opLED, want);
        end
    endtask

    initial begin
        int mode;
        int len;
        model_reset();

        #12;
        check_now("reset_state", 8'h00);
        @(posedge ipClk);
        #2;
        ipnReset = 1'b1;
        model_reset();

        // COUNT through a full wrap
        repeat (256 * TD + 8) step(0, 0);

        // Pause mid-COUNT, then resume on the held phase
        repeat (5) step(0, 0);
        repeat (10) step(0, 1);
        repeat (12) step(0, 0);

        // SCAN bounce, two full sweeps
        repeat (14 * TD * 2 + 5) step(1, 0);

        // BREATHE through both turning points
        repeat (510 * TD + 60) step(2, 0);

        // HOLD freezes, leaving it restarts SCAN at 0x01
        repeat (20) step(3, 0);
        step(1, 0);
        repeat (10) step(1, 0);

        // Mode change landing on the tick cycle
        step(0, 0);
        while (m_phase != TD - 1) step(0, 0);
        step(1, 0);
        repeat (12) step(1, 0);

        // Random mode/pause segments
        repeat (60) begin
            mode = $urandom_range(0, 3);
            len  = $urandom_range(1, 40);
            repeat (len) step(mode, ($urandom_range(0, 7) == 0));
        end

        // Asynchronous reset between edges while breathing
        repeat (30) step(2, 0);
        @(posedge ipClk);
        #3;
        ipnReset = 1'b0;
        #1;
        check_now("async_reset", 8'h00);
        repeat (3) @(posedge ipClk);
        #2;
        check_now("reset_held", 8'h00);
        ipnReset = 1'b1;
        model_reset();
        repeat (TD * 6) step(0, 0);

        repeat (3) @(posedge ipClk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain pending=%0d expected=0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
